// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: valid/ready pipeline register between two stages.
// Bubbles carry zero control bits. The data field keeps its last value.
//
// Build option (macro): PIPE_SKID_BUFFER_EN
//   defined   : depth 2 (main + skid entry); in_ready is a register and
//               has no combinational path from out_ready.
//   undefined : depth 1; in_ready = !out_valid || out_ready.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake
//   in_ctrl/in_data       : upstream payload (control / data fields)
//   flush                 : synchronous squash of all held instructions
//   out_valid/out_ready   : downstream handshake
//   out_ctrl/out_data     : downstream payload
//   occupancy             : number of held instructions (0..2)
module pipeline_stage_reg #(
  parameter int unsigned CTRL_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  localparam int unsigned OCC_W = 2;

  // Main entry: this is what the downstream stage sees.
  logic                  main_valid_q, main_valid_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
  logic [OCC_W-1:0]      occ_q,        occ_d;

  logic push;
  logic pop;

  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;

`ifdef PIPE_SKID_BUFFER_EN

  // Skid entry catches the instruction accepted while the main entry stalls.
  logic                  skid_valid_q, skid_valid_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  in_ready_q,   in_ready_d;

  assign in_ready = in_ready_q;

  // Handshake qualifiers
  always_comb begin
    push = in_valid && in_ready_q;
    pop  = main_valid_q && out_ready;
  end

  // Next-state for both entries; flush overrides every transfer.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (skid_valid_q) begin
      // Both full: in_ready is low, so only a drain can happen.
      if (pop) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end
    end else if (main_valid_q) begin
      if (push && pop) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else if (push) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = in_ctrl;
        skid_data_d  = in_data;
      end else if (pop) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (push) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end

    // Skid is only ever filled behind a valid main entry.
    if (skid_valid_d) begin
      occ_d = OCC_W'(2);
    end else if (main_valid_d) begin
      occ_d = OCC_W'(1);
    end else begin
      occ_d = OCC_W'(0);
    end
    in_ready_d = !skid_valid_d;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      occ_q        <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      occ_q        <= occ_d;
      in_ready_q   <= in_ready_d;
    end
  end

`else

  // Single entry: room exists if empty or draining this cycle.
  assign in_ready = !main_valid_q || out_ready;

  // Handshake qualifiers
  always_comb begin
    push = in_valid && in_ready;
    pop  = main_valid_q && out_ready;
  end

  // Next-state; flush overrides every transfer.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
    end else if (push) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
    end else if (pop) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
    end

    occ_d = main_valid_d ? OCC_W'(1) : OCC_W'(0);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      occ_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      occ_q        <= occ_d;
    end
  end

`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: randomized + directed bench for pipeline_stage_reg,
// checked against a queue model of the stage (capacity DEPTH).
module tb_pipeline_stage_reg;

  localparam int unsigned CW = 14;
  localparam int unsigned DW = 26;
`ifdef PIPE_SKID_BUFFER_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } entry_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int errors = 0;
  int checks = 0;

  entry_t        mq[$];
  logic [DW-1:0] last_data;

  pipeline_stage_reg #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model's current view.
  task automatic check_outputs(input string tag);
    entry_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    check({tag, ".out_ctrl"},  64'(out_ctrl),  64'((mq.size() != 0) ? h.c : '0));
    check({tag, ".out_data"},  64'(out_data),  64'(last_data));
    check({tag, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
  endtask

  // One clock cycle: called at posedge+1, returns at next posedge+1.
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic orr, input logic fl, input string tag);
    logic exp_rdy;
    logic push;
    logic pop;
    entry_t e;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = orr;
    flush     = fl;
    @(negedge clk);
    if (DEPTH == 1) exp_rdy = (mq.size() == 0) || orr;
    else            exp_rdy = (mq.size() < DEPTH);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    push = iv && exp_rdy;
    pop  = (mq.size() != 0) && orr;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.c = ic;
        e.d = id;
        mq.push_back(e);
      end
    end
    if (mq.size() != 0) last_data = mq[0].d;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    last_data = '0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = '1;
    in_data   = '1;
    flush     = 1'b0;
    out_ready = 1'b1;
    model_reset();

    // Reset state with in_valid asserted (must be ignored).
    @(posedge clk);
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    check_outputs("reset_hold");
    reset = 1'b0;

    // Single instruction, 1-cycle latency.
    step(1'b1, 14'b10010110111100, 26'h00BCCF5, 1'b1, 1'b0, "first");
    check("first.ctrl_const", 64'(out_ctrl), 64'(14'b10010110111100));
    step(1'b0, '0, '0, 1'b1, 1'b0, "drain1");

    // Stall with two feeds, then release in order.
    step(1'b1, 14'h0011, 26'h0001234, 1'b0, 1'b0, "stall_a");
    step(1'b1, 14'h0022, 26'h0001598, 1'b0, 1'b0, "stall_b");
    step(1'b1, 14'h0022, 26'h0001598, 1'b0, 1'b0, "stall_c");
    check("stall.hold_data", 64'(out_data), 64'(26'h0001234));
    step(1'b1, 14'h0022, 26'h0001598, 1'b1, 1'b0, "release_a");
    check("release.second", 64'(out_data), 64'(26'h0001598));
    step(1'b0, '0, '0, 1'b1, 1'b0, "release_b");
    step(1'b0, '0, '0, 1'b1, 1'b0, "release_c");

    // Flush while full, with a same-cycle input.
    step(1'b1, 14'h0101, 26'h0000AAA, 1'b0, 1'b0, "pref_a");
    step(1'b1, 14'h0202, 26'h0000BBB, 1'b0, 1'b0, "pref_b");
    step(1'b1, 14'h0303, 26'h0000777, 1'b1, 1'b1, "flush");
    check("flush.ctrl_zero", 64'(out_ctrl), 64'(0));
    step(1'b0, '0, '0, 1'b1, 1'b0, "post_flush");

    // Back-to-back streaming, no bubbles.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, CW'(i + 1), DW'(i), 1'b1, 1'b0, "stream");
      check("stream.seq", 64'(out_data), 64'(i));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, "stream_end");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), CW'($urandom), DW'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0), "rand");
    end

    // Asynchronous reset mid-cycle while holding an instruction.
    step(1'b1, 14'h3FFF, 26'h2ABCDEF, 1'b0, 1'b0, "pre_areset");
    check("pre_areset.valid", 64'(out_valid), 64'(1));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("areset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(1'b1, 14'h0155, 26'h0000042, 1'b1, 1'b0, "after_areset");

    for (int i = 0; i < 200; i++) begin
      step(1'($urandom), CW'($urandom), DW'($urandom), 1'($urandom),
           1'($urandom_range(0, 31) == 0), "rand2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 14, which is the width of the control-signal field (zeroed on bubbles).
REQ-002 SHALL have parameter DATA_WIDTH, default 26, which is the width of the data field (register numbers and address, never zeroed).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream stage presents a valid instruction.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage can accept an instruction this cycle.
REQ-007 SHALL have port in_ctrl, input, CTRL_WIDTH bits: control signals from upstream.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: data payload from upstream.
REQ-009 SHALL have port flush, input, 1 bit: synchronous squash of every held instruction.
REQ-010 SHALL have port out_valid, output, 1 bit: the stage presents a valid instruction downstream.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream stage accepts this cycle.
REQ-012 SHALL have port out_ctrl, output, CTRL_WIDTH bits: control signals to downstream.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits: data payload to downstream.
REQ-014 SHALL have port occupancy, output, 2 bits: number of instructions currently held (0..2).

Function
REQ-015 SHALL accept an input transfer exactly on a rising edge with in_valid=1 and in_ready=1, and complete an output transfer exactly on a rising edge with out_valid=1 and out_ready=1.
REQ-016 SHALL present an accepted instruction on out_* the cycle after acceptance when the stage was empty (1-cycle latency).
REQ-017 SHALL preserve strict FIFO order; no instruction is duplicated or dropped except by flush.
REQ-018 SHALL hold out_ctrl, out_data and out_valid stable while out_valid=1 and out_ready=0 (stall).
REQ-019 SHALL drive out_ctrl to all zeros whenever out_valid=0, so a bubble carries no side effects; out_data keeps its last value.
REQ-020 SHALL, on a flush edge, clear every held instruction (occupancy 0, out_valid 0 next cycle) and discard any input accepted in the same cycle; flush has priority over every transfer.
REQ-021 SHALL support a simultaneous input and output transfer in the same cycle without bubble, with unchanged occupancy.
REQ-022 SHALL report occupancy equal to the number of instructions held after each edge; occupancy is never greater than the depth.

Reset
REQ-023 SHALL, while reset=1, immediately force out_valid=0, out_ctrl=0, out_data=0 and occupancy=0, independent of clk.
REQ-024 SHALL drive in_ready=1 on the first cycle after reset release, and ignore in_valid while reset=1.
REQ-025 SHALL treat reset asserted mid-stall or mid-transfer as dropping every held instruction, with no partial transfer.

Configuration
REQ-026 SHALL, with macro PIPE_SKID_BUFFER_EN defined, implement depth 2 (main entry plus skid entry): in_ready is a register output equal to NOT(skid full), there is no combinational path from out_ready to in_ready, and the skid entry moves to the main entry on the edge after the main entry drains.
REQ-027 SHALL, with PIPE_SKID_BUFFER_EN undefined, implement depth 1: in_ready = NOT(out_valid) OR out_ready (combinational), and occupancy never exceeds 1.

Verification
REQ-028 SHALL cover this scenario: reset, then in_valid=1 with in_ctrl=14'b10010110111100 and in_data=26'h0B_CCF5, out_ready=1 -> next cycle out_valid=1, out_ctrl=14'b10010110111100, out_data=26'h0B_CCF5, occupancy=1.
REQ-029 SHALL cover this scenario: out_ready=0 for 3 cycles while feeding 26'h1234 then 26'h1598 -> out_data holds 26'h1234; with the skid macro in_ready falls after the 2nd accept and occupancy=2; without it in_ready=0 after the 1st accept; on release the outputs are 26'h1234 then 26'h1598 in order.
REQ-030 SHALL cover this scenario: flush=1 with occupancy=2 and in_valid=1 (26'h0777) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 26'h0777 never appears at the output.
REQ-031 SHALL cover this scenario: continuous in_valid=1 and out_ready=1 for 8 cycles with in_data incrementing from 0 -> out_data equals 0..7 on consecutive cycles, with no bubble.
REQ-032 SHALL cover this scenario: reset pulsed asynchronously mid-cycle while out_valid=1 -> out_valid, out_ctrl, out_data and occupancy are 0 before the next clk edge.
